// File: rtl/mdu_divider.sv
// mdu_divider: multicycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {IDLE, CALC, FIN, SPC, DONE} state_t;
  state_t state, next;
  logic [4:0] cnt;
  logic [XLEN-1:0] dvd, rem, dvs, a_mag, b_mag, spec_val, q_fix, r_fix;
  logic [XLEN:0] rem_sh, diff;
  logic neg_q, neg_r, sel_rem, accept, sgn, dz, ovf, special;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    sgn = ~op[0];
    dz = SrcB == '0;
    ovf = sgn && SrcA == MIN_NEG && SrcB == '1;
    special = dz || ovf;
    spec_val = dz ? (op[1] ? SrcA : '1) : (op[1] ? '0 : MIN_NEG);
    a_mag = (sgn && SrcA[XLEN-1]) ? -SrcA : SrcA;
    b_mag = (sgn && SrcB[XLEN-1]) ? -SrcB : SrcB;
    rem_sh = {rem, dvd[XLEN-1]};
    diff = rem_sh - {1'b0, dvs};
    q_fix = neg_q ? -dvd : dvd;
    r_fix = neg_r ? -rem : rem;
    busy = state == CALC || state == FIN;
    done = state == DONE;
    next = state;
    case (state)
      IDLE, DONE: next = accept ? (special ? SPC : CALC) : IDLE;
      CALC:       next = cnt == 5'd0 ? FIN : CALC;
      FIN, SPC:   next = DONE;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // For special cases rem carries the precomputed answer until it is published.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      dvd <= '0;
      rem <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      sel_rem <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        dvd <= a_mag;
        dvs <= b_mag;
        rem <= special ? spec_val : '0;
        neg_q <= sgn && (SrcA[XLEN-1] ^ SrcB[XLEN-1]);
        neg_r <= sgn && SrcA[XLEN-1];
        sel_rem <= op[1];
        cnt <= 5'd31;
      end else if (state == CALC) begin
        rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        dvd <= {dvd[XLEN-2:0], ~diff[XLEN]};
        cnt <= cnt - 5'd1;
      end
      if (state == FIN) result <= sel_rem ? r_fix : q_fix;
      if (state == SPC) result <= rem;
    end
  end
endmodule
